// File: rtl/servo_position_sequencer.sv
// Position command source for the SG90 PWM controller: debounced manual stepping or
// automatic back-and-forth sweep, with every position change aligned to a PWM frame end.
`timescale 1ns/1ps
module servo_position_sequencer #(
    parameter int         DEBOUNCE_CYCLES = 240000,
    parameter int         FRAME_CYCLES    = 262144,
    parameter int         DWELL_FRAMES    = 10,
    parameter logic [2:0] HOME_POS        = 3'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_dn,
    input  logic       sweep_en,
    output logic [2:0] position,
    output logic       frame_tick,
    output logic       at_limit,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {MANUAL = 2'd0, SWEEP_UP = 2'd1, SWEEP_DN = 2'd2} state_t;
    typedef enum logic [1:0] {REQ_NONE = 2'd0, REQ_UP = 2'd1, REQ_DN = 2'd2} req_t;

    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int FW  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int DWW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

    logic [2:0]          sync1, sync2;      // {sweep_en, btn_dn, btn_up}
    logic [1:0][DBW-1:0] db_cnt;
    logic [1:0]          db_level;
    logic [1:0]          press;             // one-cycle accepted 0->1 events {dn, up}
    logic [FW-1:0]       frame_cnt;
    state_t              state, state_next;
    req_t                pending, pending_next, press_req;
    logic [DWW-1:0]      dwell, dwell_next;
    logic [2:0]          position_next;
    logic                sweep_s;

    assign sweep_s = sync2[2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {sweep_en, btn_dn, btn_up};
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_cnt   <= '0;
            db_level <= '0;
            press    <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    db_level[i] <= sync2[i];
                    db_cnt[i]   <= '0;
                    press[i]    <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    // frame_tick is registered so it is high exactly while frame_cnt holds its last value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt  <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= (frame_cnt == FW'(FRAME_CYCLES - 2));
            if (frame_cnt == FW'(FRAME_CYCLES - 1)) frame_cnt <= '0;
            else                                    frame_cnt <= frame_cnt + FW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= MANUAL;
            pending  <= REQ_NONE;
            dwell    <= '0;
            position <= HOME_POS;
        end else begin
            state    <= state_next;
            pending  <= pending_next;
            dwell    <= dwell_next;
            position <= position_next;
        end
    end

    always_comb begin
        state_next    = state;
        pending_next  = pending;
        dwell_next    = dwell;
        position_next = position;
        case (press)
            2'b01:   press_req = REQ_UP;
            2'b10:   press_req = REQ_DN;
            default: press_req = REQ_NONE;
        endcase
        case (state)
            MANUAL: begin
                if (frame_tick) begin
                    if (sweep_s) begin
                        state_next   = (position == 3'd7) ? SWEEP_DN : SWEEP_UP;
                        dwell_next   = '0;
                        pending_next = REQ_NONE;
                    end else begin
                        if (pending == REQ_UP && position != 3'd7)
                            position_next = position + 3'd1;
                        else if (pending == REQ_DN && position != 3'd0)
                            position_next = position - 3'd1;
                        // a press on the tick cycle is kept for the next frame
                        pending_next = (press != 2'b00) ? press_req : REQ_NONE;
                    end
                end else if (press != 2'b00) begin
                    pending_next = press_req;
                end
            end
            SWEEP_UP, SWEEP_DN: begin
                pending_next = REQ_NONE;
                if (frame_tick) begin
                    if (!sweep_s) begin
                        state_next = MANUAL;
                        dwell_next = '0;
                    end else if (dwell == DWW'(DWELL_FRAMES - 1)) begin
                        dwell_next = '0;
                        if (state == SWEEP_UP) begin
                            position_next = position + 3'd1;
                            if (position == 3'd6) state_next = SWEEP_DN;
                        end else begin
                            position_next = position - 3'd1;
                            if (position == 3'd1) state_next = SWEEP_UP;
                        end
                    end else begin
                        dwell_next = dwell + DWW'(1);
                    end
                end
            end
            default: state_next = MANUAL;
        endcase
    end

    assign at_limit  = (position == 3'd0) || (position == 3'd7);
    assign fsm_state = state;

endmodule

// File: tb/tb_servo_position_sequencer.sv
// Bench for servo_position_sequencer: cycle-stepped reference model of the button,
// frame and sweep rules, directed scenarios plus a randomized soak.
`timescale 1ns/1ps
module tb_servo_position_sequencer;

    localparam int DB = 8;
    localparam int FC = 64;
    localparam int DW = 2;
    localparam int ST_MANUAL = 0;
    localparam int ST_UP     = 1;
    localparam int ST_DN     = 2;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_up = 1'b0, btn_dn = 1'b0, sweep_en = 1'b0;
    logic [2:0] position;
    logic       frame_tick, at_limit;
    logic [1:0] fsm_state;

    always #5 clk = ~clk;

    servo_position_sequencer #(
        .DEBOUNCE_CYCLES(DB), .FRAME_CYCLES(FC), .DWELL_FRAMES(DW), .HOME_POS(3'd0)
    ) dut (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .sweep_en(sweep_en),
        .position(position), .frame_tick(frame_tick), .at_limit(at_limit),
        .fsm_state(fsm_state)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: m_dir 0 = manual, +1/-1 = sweep direction
    int   m_cyc, m_pos, m_dir, m_pend, m_dwell, up_run, dn_run;
    logic up_acc, dn_acc;
    bit   up_ev, dn_ev;
    logic hist_up[$], hist_dn[$], hist_sw[$];

    task automatic model_reset();
        m_cyc = 0; m_pos = 0; m_dir = 0; m_pend = 0; m_dwell = 0;
        up_run = 0; dn_run = 0; up_acc = 1'b0; dn_acc = 1'b0; up_ev = 0; dn_ev = 0;
        hist_up = '{1'b0, 1'b0};
        hist_dn = '{1'b0, 1'b0};
        hist_sw = '{1'b0, 1'b0};
    endtask

    task automatic deb(input logic s, inout logic acc, inout int run, output bit ev);
        ev = 0;
        if (s == acc) run = 0;
        else if (run == DB - 1) begin
            acc = s; run = 0; ev = s;
        end else run++;
    endtask

    function automatic int press_request(input int keep);
        if (up_ev && dn_ev) return 0;
        if (up_ev) return 1;
        if (dn_ev) return -1;
        return keep;
    endfunction

    task automatic model_step();
        bit   tick_now;
        logic s_up, s_dn, s_sw;
        int   p;
        tick_now = (m_cyc % FC == FC - 1);
        s_up = hist_up.pop_front(); hist_up.push_back(btn_up);
        s_dn = hist_dn.pop_front(); hist_dn.push_back(btn_dn);
        s_sw = hist_sw.pop_front(); hist_sw.push_back(sweep_en);
        if (m_dir == 0) begin
            if (tick_now && s_sw) begin
                m_dir = (m_pos == 7) ? -1 : 1; m_dwell = 0; m_pend = 0;
            end else if (tick_now) begin
                p = m_pos + m_pend;
                m_pos = (p > 7) ? 7 : ((p < 0) ? 0 : p);
                m_pend = press_request(0);
            end else m_pend = press_request(m_pend);
        end else if (tick_now) begin
            if (!s_sw) begin
                m_dir = 0; m_dwell = 0;
            end else begin
                m_dwell++;
                if (m_dwell == DW) begin
                    m_dwell = 0;
                    m_pos += m_dir;
                    if (m_pos == 7) m_dir = -1;
                    else if (m_pos == 0) m_dir = 1;
                end
            end
        end
        deb(s_up, up_acc, up_run, up_ev);
        deb(s_dn, dn_acc, dn_run, dn_ev);
        m_cyc++;
    endtask

    bit log_on = 0;
    int sweep_log[$];

    // driver tasks
    task automatic cycle();
        @(posedge clk);
        if (!rst) model_reset(); else model_step();
        @(negedge clk);
        check("position", position, m_pos);
        check("frame_tick", frame_tick, (m_cyc % FC == FC - 1));
        check("at_limit", at_limit, (m_pos == 0 || m_pos == 7));
        check("fsm_state", fsm_state, m_dir == 0 ? ST_MANUAL : (m_dir > 0 ? ST_UP : ST_DN));
        if (log_on && sweep_log.size() < 16 && int'(position) != sweep_log[$])
            sweep_log.push_back(int'(position));
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic press(input bit up, input int hold, input int gap);
        if (up) btn_up = 1'b1; else btn_dn = 1'b1;
        run(hold);
        btn_up = 1'b0; btn_dn = 1'b0;
        run(gap);
    endtask

    task automatic align(input int phase);
        for (int i = 0; i < FC && (m_cyc % FC) != phase; i++) cycle();
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        run(3);
        check("reset_position", position, 0);
        check("reset_at_limit", at_limit, 1);
        check("reset_frame_tick", frame_tick, 0);
        rst = 1'b1;
        run(62); check("no_early_tick", frame_tick, 0);
        run(1);  check("first_tick", frame_tick, 1);
        run(63); check("tick_gap", frame_tick, 0);
        run(1);  check("second_tick", frame_tick, 1);

        // bouncing up button, then a clean hold
        for (int i = 0; i < 20; i++) begin
            if (i % 3 == 0) btn_up = ~btn_up;
            run(1);
        end
        check("bounce_hold", position, 0);
        btn_up = 1'b1; run(12); btn_up = 1'b0;
        run(DB + 4 + FC + 8);
        check("bounce_one_step", position, 1);

        for (int i = 0; i < 8; i++) press(1, 12, FC - 12 + $urandom_range(0, 30));
        run(FC + 16);
        check("saturate_up", position, 7);
        check("at_limit_top", at_limit, 1);

        press(0, 12, 2 * FC);
        check("step_down", position, 6);
        btn_up = 1'b1; btn_dn = 1'b1; run(12); btn_up = 1'b0; btn_dn = 1'b0;
        run(2 * FC);
        check("both_press_cleared", position, 6);
        align(0);
        btn_up = 1'b1; run(12); btn_up = 1'b0; btn_dn = 1'b1; run(12); btn_dn = 1'b0;
        run(2 * FC);
        check("last_press_dn", position, 5);
        align(0);
        btn_dn = 1'b1; run(12); btn_dn = 1'b0; btn_up = 1'b1; run(12); btn_up = 1'b0;
        run(2 * FC);
        check("last_press_up", position, 6);

        // press event lands on the frame_tick cycle
        align(FC - 11);
        btn_dn = 1'b1;
        run(10); check("tick_press_tick", frame_tick, 1);
        run(1);  check("tick_press_not_applied", position, 6);
        run(2);  btn_dn = 1'b0;
        run(FC);
        check("tick_press_next_frame", position, 5);

        for (int i = 0; i < 6; i++) press(0, 12, FC + $urandom_range(0, 20));
        run(FC + 16);
        check("saturate_dn", position, 0);

        // sweep with button noise
        sweep_en = 1'b1;
        sweep_log.delete();
        sweep_log.push_back(int'(position));
        log_on = 1;
        for (int i = 0; i < 40 * FC && sweep_log.size() < 16; i++) begin
            if ($urandom_range(0, 15) == 0) btn_up = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) btn_dn = 1'($urandom_range(0, 1));
            cycle();
        end
        log_on = 0;
        btn_up = 1'b0; btn_dn = 1'b0;
        check("sweep_len", sweep_log.size(), 16);
        for (int i = 0; i < 16; i++)
            check("sweep_seq", (i < sweep_log.size()) ? sweep_log[i] : -1,
                  (i <= 7) ? i : ((i <= 14) ? 14 - i : i - 14));

        for (int i = 0; i < 20 * FC && !(m_pos == 5 && m_dwell == 1 && m_dir > 0); i++) cycle();
        check("sweep_at5", position, 5);
        sweep_en = 1'b0;
        run(FC + 4);
        check("exit_hold5", position, 5);
        check("exit_manual", fsm_state, ST_MANUAL);
        press(0, 12, FC + 16);
        check("exit_then_dn", position, 4);

        // asynchronous reset in the middle of a sweep
        sweep_en = 1'b1;
        for (int i = 0; i < 20 * FC && m_pos != 6; i++) cycle();
        run($urandom_range(0, 100));
        check("pre_reset_pos6", position, 6);
        @(posedge clk); #2 rst = 1'b0;
        #1;
        check("async_reset_pos", position, 0);
        check("async_reset_limit", at_limit, 1);
        check("async_reset_tick", frame_tick, 0);
        check("async_reset_state", fsm_state, ST_MANUAL);
        model_reset();
        sweep_en = 1'b0;
        run(3);
        rst = 1'b1;
        run(62); check("post_reset_no_tick", frame_tick, 0);
        run(1);  check("post_reset_first_tick", frame_tick, 1);

        // randomized soak
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 11) == 0) btn_up = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 11) == 0) btn_dn = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 399) == 0) sweep_en = ~sweep_en;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/servo_position_sequencer.md
Name: servo_position_sequencer

Overview:
- Upstream stage of the SG90 servo PWM controller. Produces the 3-bit `position` command (0-7) that the controller consumes.
- Source is either two debounced pushbuttons (manual step up/down) or an automatic back-and-forth sweep.
- `position` only changes on a frame boundary aligned to the servo PWM period (2^18 clk, about 21.8 ms at 12 MHz), so the servo never sees a mid-pulse change.

Parameters:
- DEBOUNCE_CYCLES, 240000, clk cycles a synced button level must hold before it is accepted (20 ms at 12 MHz).
- FRAME_CYCLES, 262144, frame period in clk cycles; matches the servo PWM period.
- DWELL_FRAMES, 10, frames spent at each position during sweep (must be at least 1).
- HOME_POS, 3'd0, position value loaded at reset.

Ports:
- clk  input  1  system clock, 12 MHz.
- rst  input  1  asynchronous, active-low reset.
- btn_up  input  1  raw pushbuttons, asynchronous, active-high; step position +1.
- btn_dn  input  1  raw pushbuttons, asynchronous, active-high; step position -1.
- sweep_en  input  1  raw switch, asynchronous; high selects automatic sweep.
- position  output  3  registered command to the servo controller.
- frame_tick  output  1  registered one-cycle pulse on the last cycle of each frame.
- at_limit  output  1  high when position is 0 or 7 (decoded from the position register).

Behaviour:
- Reset (rst=0, async): position=HOME_POS, frame_tick=0, frame counter=0, state=MANUAL, pending request cleared, debounced levels=0, dwell counter=0, synchronizers=0.
- Synchronizing: btn_up, btn_dn and sweep_en each pass through a 2-FF synchronizer before any other use.
- Debounce, per button:
  - Counter increments while synced level != accepted level; it clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the accepted level takes the synced value and the counter clears.
  - A press event is a one-cycle pulse on an accepted 0->1 transition. Releases generate nothing.
- Frame counter: runs 0..FRAME_CYCLES-1 and wraps. frame_tick=1 exactly when the counter is FRAME_CYCLES-1. position updates only at the clock edge ending a frame_tick cycle.
- FSM states: MANUAL, SWEEP_UP, SWEEP_DN.
- MANUAL:
  - An up or down press event sets the pending request (UP or DN). A later press overwrites an earlier one.
  - Up and down press events in the same cycle clear the pending request.
  - At frame_tick, the pending request is applied with saturation: UP at 7 stays 7, DN at 0 stays 0. The request is then cleared. At most one step per frame.
  - A press event coincident with frame_tick is latched as the new pending request for the following frame. It is not applied at that tick.
  - If synced sweep_en=1 at frame_tick: go to SWEEP_UP (or SWEEP_DN if position=7), dwell counter=0, pending request cleared, no step on that tick.
- SWEEP_UP / SWEEP_DN:
  - Press events are ignored and pending stays clear.
  - Each frame_tick increments the dwell counter. When it reaches DWELL_FRAMES-1 it clears, and position steps +1 (UP) or -1 (DN).
  - When the step lands on 7, go to SWEEP_DN; when it lands on 0, go to SWEEP_UP. The direction reverses on the same edge.
  - If synced sweep_en=0 at frame_tick: go to MANUAL, position held, dwell counter cleared. The sweep-exit check takes priority over a dwell step on that tick.
- Arithmetic: position is 3-bit unsigned and never wraps (0-1 and 7+1 are impossible by construction).
- Latency, manual: from raw press to position change is 2 (sync) + DEBOUNCE_CYCLES + 0..FRAME_CYCLES-1 cycles, + 1 edge.
- Reset mid-operation: all state returns to reset values immediately (async). First frame_tick occurs FRAME_CYCLES-1 cycles after rst deasserts.
- Outputs are glitch-free: position and frame_tick come from flops; at_limit is a decode of the position register only.

Test Plan (DEBOUNCE_CYCLES=8, FRAME_CYCLES=64, DWELL_FRAMES=2):
- Reset: hold rst=0, then release -> position=0, at_limit=1, frame_tick=0. First frame_tick on cycle 63 after release; it repeats every 64 cycles.
- Manual step with bounce: btn_up toggles every 3 cycles for 20 cycles, then holds high 12 cycles -> exactly one step. position=1 at the first frame_tick after debounce; no change while bouncing. Then 8 clean up presses, one per frame -> position saturates at 7 and at_limit=1.
- Press conflicts: up and down press events in the same cycle -> position unchanged at next tick. Up then down in one frame -> position -1 (last press wins). Press landing on the frame_tick cycle -> applied at the next tick, not this one.
- Sweep: sweep_en=1 from position=0 -> sequence 0,1,...,7,6,...,0,1 with each value held 2 frames (128 cycles). Direction reverses at 7 and at 0. Buttons pressed during sweep -> no effect.
- Sweep exit: sweep_en=0 while sweep is at 5 with dwell=1 -> MANUAL at next frame_tick, position stays 5 (no step). A subsequent down press -> 4.
- Async reset mid-sweep: rst=0 between clock edges at position=6 -> position=0 immediately, state MANUAL, no frame_tick until 63 cycles after release.
